// File: rtl/oci_trace_pkg.sv
// Shared types and defaults for the OCI trace packer: FSM state encoding,
// default geometry and the item-count width helper.
package oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ENDED = 2'd3
    } oci_state_e;

    localparam int DEF_ITEM_W         = 6;
    localparam int DEF_ITEMS_PER_WORD = 5;
    localparam int DEF_FIFO_DEPTH     = 4;

    // Count field must hold 0..items_per_word inclusive.
    function automatic int cnt_width(input int items_per_word);
        return $clog2(items_per_word + 1);
    endfunction

endpackage

// File: rtl/oci_trace_word_fifo.sv
// Small FIFO of packed trace words (data and item count concatenated);
// head entry is read straight from the storage registers and forced to 0 when empty.
module oci_trace_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/oci_trace_packer.sv
// Packs narrow OCI trace items into wide words, queues them toward the trace sink
// and runs the end-of-test flush (RUN -> FLUSH -> DRAIN -> ENDED).
module oci_trace_packer
    import oci_trace_pkg::*;
#(
    parameter  int ITEM_W         = DEF_ITEM_W,
    parameter  int ITEMS_PER_WORD = DEF_ITEMS_PER_WORD,
    parameter  int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter  int MODE_DROP      = 0,
    parameter  int DROP_W         = 16,
    localparam int CNT_W          = cnt_width(ITEMS_PER_WORD),
    localparam int WORD_W         = ITEM_W * ITEMS_PER_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              item_valid,
    input  logic [ITEM_W-1:0] item_data,
    output logic              item_ready,
    input  logic              test_ending,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              test_has_ended,
    output logic [DROP_W-1:0] drop_count,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and item_ready never depends on out_ready.

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ITEMS_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ITEMS_PER_WORD);

    oci_state_e              state, state_nxt;
    logic [WORD_W-1:0]       pack, pack_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [DROP_W-1:0]       drops, drops_nxt;
    logic                    fifo_push;
    logic [CNT_W+WORD_W-1:0] fifo_wdata;
    logic [CNT_W+WORD_W-1:0] fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    accept;
    logic                    completes;
    logic [WORD_W-1:0]       item_placed;

    assign item_ready  = reset_n && (state == ST_RUN) &&
                         ((MODE_DROP != 0) || (cnt < LAST_SLOT) || !fifo_full);
    assign accept      = item_valid && item_ready;
    assign completes   = accept && (cnt == LAST_SLOT);
    // Target slot is always zero in the pack register, so OR-ing is safe.
    assign item_placed = WORD_W'(item_data) << (cnt * ITEM_W);

    always_comb begin
        state_nxt  = state;
        pack_nxt   = pack;
        cnt_nxt    = cnt;
        drops_nxt  = drops;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        case (state)
            ST_RUN: begin
                if (completes) begin
                    if (!fifo_full) begin
                        fifo_push  = 1'b1;
                        fifo_wdata = {FULL_CNT, pack | item_placed};
                        pack_nxt   = '0;
                        cnt_nxt    = '0;
                    end else if (drops != '1) begin
                        drops_nxt = drops + DROP_W'(1);
                    end
                end else if (accept) begin
                    pack_nxt = pack | item_placed;
                    cnt_nxt  = cnt + CNT_W'(1);
                end
                if (test_ending) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = ST_DRAIN;
                end else if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {cnt, pack};
                    pack_nxt   = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_ENDED;
                end
            end
            ST_ENDED: begin
                state_nxt = ST_ENDED;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
            pack  <= '0;
            cnt   <= '0;
            drops <= '0;
        end else begin
            state <= state_nxt;
            pack  <= pack_nxt;
            cnt   <= cnt_nxt;
            drops <= drops_nxt;
        end
    end

    oci_trace_word_fifo #(
        .WIDTH (CNT_W + WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_data  (fifo_wdata),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign out_count      = fifo_head[CNT_W+WORD_W-1:WORD_W];
    assign out_data       = fifo_head[WORD_W-1:0];
    assign test_has_ended = (state == ST_ENDED);
    assign drop_count     = drops;
    assign state_dbg      = state;

endmodule

// File: tb/tb_oci_trace_packer.sv
// Directed bench for oci_trace_packer: three instances (stall mode, drop mode,
// drop mode with a 2-bit drop counter) share one stimulus stream.
module tb_oci_trace_packer;
    import oci_trace_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       item_valid;
    logic [5:0] item_data;
    logic       test_ending;
    logic       out_ready;

    logic        r0, v0, e0, r1, v1, e1, r2, v2, e2;
    logic [29:0] d0, d1, d2;
    logic [2:0]  c0, c1, c2;
    logic [15:0] dc0, dc1;
    logic [1:0]  dc2;
    logic [1:0]  s0, s1, s2;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    logic [29:0] wacc;
    int          k;

    always #5 clk = ~clk;

    oci_trace_packer #(.MODE_DROP(0)) u0 (
        .clk(clk), .reset_n(reset_n), .item_valid(item_valid), .item_data(item_data),
        .item_ready(r0), .test_ending(test_ending), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_count(c0), .test_has_ended(e0), .drop_count(dc0), .state_dbg(s0)
    );

    oci_trace_packer #(.MODE_DROP(1)) u1 (
        .clk(clk), .reset_n(reset_n), .item_valid(item_valid), .item_data(item_data),
        .item_ready(r1), .test_ending(test_ending), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_count(c1), .test_has_ended(e1), .drop_count(dc1), .state_dbg(s1)
    );

    oci_trace_packer #(.MODE_DROP(1), .DROP_W(2)) u2 (
        .clk(clk), .reset_n(reset_n), .item_valid(item_valid), .item_data(item_data),
        .item_ready(r2), .test_ending(test_ending), .out_valid(v2), .out_ready(out_ready),
        .out_data(d2), .out_count(c2), .test_has_ended(e2), .drop_count(dc2), .state_dbg(s2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] c, input logic [29:0] d);
        exp_q0.push_back({c, d});
        exp_q1.push_back({c, d});
        exp_q2.push_back({c, d});
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        wacc = '0;
        k    = 0;
    endtask

    // acc0: stall-mode instance must accept; rdy1: drop-mode instances show ready.
    task automatic send_item(input logic [5:0] v, input logic acc0, input logic rdy1);
        item_valid = 1'b1;
        item_data  = v;
        #1;
        check("u0_item_ready", r0, acc0);
        check("u1_item_ready", r1, rdy1);
        check("u2_item_ready", r2, rdy1);
        if (acc0) begin
            wacc = wacc | (30'(v) << (k * 6));
            k++;
            if (k == 5) begin
                push_exp(3'd5, wacc);
                wacc = '0;
                k    = 0;
            end
        end
        tick();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_q0"}, exp_q0.size(), 0);
        check({tag, "_q1"}, exp_q1.size(), 0);
        check({tag, "_q2"}, exp_q2.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && out_ready && v0) begin
            if (exp_q0.size() == 0) check("u0_pop_unexpected", v0, 1'b0);
            else check("u0_word", {c0, d0}, exp_q0.pop_front());
        end
        if (reset_n && out_ready && v1) begin
            if (exp_q1.size() == 0) check("u1_pop_unexpected", v1, 1'b0);
            else check("u1_word", {c1, d1}, exp_q1.pop_front());
        end
        if (reset_n && out_ready && v2) begin
            if (exp_q2.size() == 0) check("u2_pop_unexpected", v2, 1'b0);
            else check("u2_word", {c2, d2}, exp_q2.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        item_valid  = 1'b0;
        item_data   = '0;
        test_ending = 1'b0;
        out_ready   = 1'b0;
        clear_model();

        // Reset state
        tick();
        tick();
        check("rst_item_ready", r0, 1'b0);
        check("rst_out_valid", v0, 1'b0);
        check("rst_out_data", d0, 30'h0);
        check("rst_out_count", c0, 3'd0);
        check("rst_ended", e0, 1'b0);
        check("rst_drop1", dc1, 16'd0);
        check("rst_drop2", dc2, 2'd0);
        check("rst_state", s0, ST_RUN);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", r0, 1'b1);

        // One full word, 1-cycle visibility, single pop
        out_ready = 1'b1;
        for (int v = 1; v <= 5; v++) send_item(6'(v), 1'b1, 1'b1);
        item_valid = 1'b0;
        check("word1_valid", v0, 1'b1);
        check("word1_data", d0, 30'h05103081);
        check("word1_count", c0, 3'd5);
        tick();
        check("word1_popped", v0, 1'b0);
        check_drained("word1");

        // Overflow: stall mode blocks item 25, drop mode drops 25..30
        out_ready = 1'b0;
        for (int v = 1; v <= 30; v++) send_item(6'(v), (v <= 24), 1'b1);
        item_valid = 1'b0;
        check("ovf_drop0", dc0, 16'd0);
        check("ovf_drop1", dc1, 16'd6);
        check("ovf_drop2_sat", dc2, 2'd3);
        check("ovf_q0_depth", exp_q0.size(), 4);
        check("ovf_valid0", v0, 1'b1);
        check("ovf_valid1", v1, 1'b1);
        out_ready = 1'b1;
        repeat (4) tick();
        check_drained("ovf_pop");
        check("ovf_empty0", v0, 1'b0);
        send_item(6'd25, 1'b1, 1'b1);
        item_valid = 1'b0;
        tick();
        tick();
        check_drained("ovf_w5");
        check("ovf_drop1_hold", dc1, 16'd6);

        // Partial word flush then sticky end
        send_item(6'h3F, 1'b1, 1'b1);
        send_item(6'h00, 1'b1, 1'b1);
        send_item(6'h2A, 1'b1, 1'b1);
        item_valid = 1'b0;
        check("flush_model_word", {3'(k), wacc}, {3'd3, 30'h2A03F});
        push_exp(3'(k), wacc);
        wacc        = '0;
        k           = 0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("flush_state", s0, ST_FLUSH);
        for (int i = 0; i < 20 && !e0; i++) tick();
        check("flush_ended0", e0, 1'b1);
        check("flush_ended1", e1, 1'b1);
        check("flush_ended2", e2, 1'b1);
        check_drained("flush");
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        repeat (3) tick();
        check("ended_sticky", e0, 1'b1);
        check("ended_state", s0, ST_ENDED);
        send_item(6'd7, 1'b0, 1'b0);
        item_valid = 1'b0;
        check("ended_drop1", dc1, 16'd6);
        check("ended_drop2", dc2, 2'd3);

        // Idle flush: test_has_ended on the third edge
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_model();
        check("idle_rst_state", s0, ST_RUN);
        check("idle_rst_drop", dc1, 16'd0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("idle_edge1", e0, 1'b0);
        tick();
        check("idle_edge2", e0, 1'b0);
        tick();
        check("idle_edge3", e0, 1'b1);
        send_item(6'd9, 1'b0, 1'b0);
        item_valid = 1'b0;
        check("idle_drop1", dc1, 16'd0);
        check("idle_no_word", v0, 1'b0);

        // Reset during DRAIN discards queued words
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_model();
        out_ready = 1'b0;
        for (int v = 11; v <= 20; v++) send_item(6'(v), 1'b1, 1'b1);
        item_valid  = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        tick();
        check("drain_state", s0, ST_DRAIN);
        check("drain_valid", v0, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_model();
        check("rst2_valid", v0, 1'b0);
        check("rst2_data", d0, 30'h0);
        check("rst2_ended", e0, 1'b0);
        check("rst2_state", s0, ST_RUN);
        out_ready = 1'b1;
        for (int v = 33; v <= 37; v++) send_item(6'(v), 1'b1, 1'b1);
        item_valid = 1'b0;
        tick();
        tick();
        check_drained("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oci_trace_packer.md
Name: oci_trace_packer

Overview:
- Parametrised successor to the OCI trace test-bench monitor: packs narrow debug-trace items (DCT frames) into wide words, with a count of valid items per word.
- Buffers packed words in a small FIFO toward the trace sink, and implements end-of-test flush with a sticky test_has_ended flag.
- Sits between the CPU OCI trace source and the trace memory / bench monitor.
- Adds configurable item width, packing depth, FIFO depth and a stall-vs-drop overflow mode.

Parameters:
- ITEM_W, 6: width of one trace item in bits.
- ITEMS_PER_WORD, 5: items packed per output word; output word width is ITEM_W*ITEMS_PER_WORD (30 at defaults).
- FIFO_DEPTH, 4: packed-word FIFO entries; power of two, at least 2.
- MODE_DROP, 0: overflow mode. 0 = backpressure via item_ready. 1 = item_ready held high in RUN; excess items are dropped and counted.
- DROP_W, 16: width of the drop counter.
- CNT_W (localparam) = $clog2(ITEMS_PER_WORD+1).

Ports:
- clk, in, 1: sole clock; all logic on the rising edge.
- reset_n, in, 1: reset, synchronous, active-low.
- item_valid, in, 1: trace item present.
- item_data, in, ITEM_W: trace item.
- item_ready, out, 1: item accepted when item_valid && item_ready.
- test_ending, in, 1: request end-of-test flush; sampled only in RUN.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: sink pops the head when out_valid && out_ready.
- out_data, out, ITEM_W*ITEMS_PER_WORD: packed word (dct_buffer).
- out_count, out, CNT_W: valid items in out_data, 1..ITEMS_PER_WORD (dct_count).
- test_has_ended, out, 1: sticky; flush complete.
- drop_count, out, DROP_W: saturating count of dropped items.

Behaviour:
- Reset (reset_n low at an edge):
  - All state clears: pack buffer, cnt, FIFO pointers/contents, drop_count, state=RUN.
  - Outputs: item_ready=0 during reset, out_valid=0, out_data=0, out_count=0, test_has_ended=0, drop_count=0.
  - Reset mid-operation discards all buffered data.
- Packing:
  - Item k of a word occupies out_data[k*ITEM_W +: ITEM_W]; the first accepted item is k=0.
  - Unused slots in a partial word read 0.
  - cnt counts items held in the pack register (0..ITEMS_PER_WORD-1).
- Word completion:
  - An accepted item with cnt==ITEMS_PER_WORD-1 writes {item, pack} to the FIFO in the same cycle, with count=ITEMS_PER_WORD; cnt->0 and the pack register clears.
  - The word is visible on out_valid on the next cycle (1-cycle latency).
- item_ready (state RUN only; 0 in all other states):
  - MODE_DROP=0: item_ready = (cnt < ITEMS_PER_WORD-1) || !fifo_full.
  - MODE_DROP=1: item_ready=1. An item that would complete a word while the FIFO is full is discarded; drop_count increments, saturating at all-ones. The pack register is unchanged.
  - No combinational path from out_ready to item_ready: a FIFO that is full at the edge blocks, even if a pop happens in the same cycle.
- FIFO:
  - Simultaneous push and pop is allowed at any occupancy, including full: the pop frees the slot and the push fills it.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data/out_count are driven from the registered head entry; they are 0 when empty.
- State machine: RUN -> FLUSH -> DRAIN -> ENDED.
  - RUN: normal operation. test_ending high at an edge moves to FLUSH; an item accepted on that same edge is still packed.
  - FLUSH: if cnt==0, go to DRAIN. Otherwise wait until !fifo_full, push the partial word with count=cnt, clear cnt, go to DRAIN.
  - DRAIN: when FIFO empty, go to ENDED. The sink keeps popping normally.
  - ENDED: test_has_ended=1 (registered, state==ENDED). Held until reset; test_ending is ignored.
- Flush timing: with an empty buffer and empty FIFO, test_has_ended rises on the third edge after test_ending is sampled.
- Not counted as drops: items offered outside RUN, in either mode.

Decomposition:
- Shared package oci_trace_pkg:
  - state enum {RUN, FLUSH, DRAIN, ENDED};
  - default ITEM_W/ITEMS_PER_WORD/FIFO_DEPTH constants;
  - clog2-based CNT_W helper.
- One natural sub-module, oci_trace_word_fifo:
  - parametrised width and depth, synchronous reset;
  - push/pop/full/empty, registered head.
- The packer FSM, pack register and drop counter stay in the top.

Test Plan:
- Defaults; items 0x01..0x05 on consecutive cycles, out_ready=1 -> out_data=0x05103081 and out_count=5, out_valid one cycle after the 5th accept, for exactly one pop.
- MODE_DROP=0, out_ready=0; stream 30 items -> 24 accepted; item_ready falls when the 25th item would complete word 5. Set out_ready=1 -> four words pop, then the 25th is accepted.
- MODE_DROP=1, same stimulus -> items 25..30 dropped, drop_count=6, four words in the FIFO, the pack register holds items 21..24. Saturation check at DROP_W=2 -> stops at 3.
- Items 0x3F, 0x00, 0x2A then test_ending, out_ready=1 -> word out_data=0x2A03F, out_count=3; test_has_ended high after the FIFO empties and stays high.
- Idle and empty, test_ending pulse -> no output word; test_has_ended rises on the third edge. Further items -> item_ready=0, drop_count unchanged.
- reset_n low for one edge during DRAIN with 2 words queued -> out_valid=0, test_has_ended=0, state RUN. The next 5 items produce a fresh correct word.
